// File: rtl/cfi_pkg.sv
// cfi_pkg: shared CFI flag, commit-port and log-record types
package cfi_pkg;
    localparam int unsigned VLEN = 39;
    typedef struct packed {
        logic is_branch;
        logic is_jump;
        logic is_call;
        logic is_return;
    } cfi_flags_t;
    typedef struct packed {
        cfi_flags_t       flags;
        logic [VLEN-1:0]  addr_pc;
        logic [VLEN-1:0]  addr_npc;
        logic [VLEN-1:0]  addr_target;
    } cfi_log_t;
    typedef struct packed {
        logic             valid;
        cfi_flags_t       flags;
        logic [VLEN-1:0]  pc;
        logic [VLEN-1:0]  npc;
        logic [VLEN-1:0]  target;
    } cfi_commit_t;
    function automatic logic cfi_is_cf(input cfi_flags_t flags);
        return |flags;
    endfunction
endpackage

// File: rtl/cfi_log_buffer_fifo.sv
// cfi_multi_push_fifo: N-write/1-read circular FIFO that drops writes beyond start-of-cycle free space
module cfi_multi_push_fifo
    import cfi_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned Depth = 8,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N-1:0]         wr_valid_i,
    input  cfi_log_t [N-1:0]     wr_data_i,
    output cfi_log_t             rd_data_o,
    output logic                 rd_valid_o,
    input  logic                 rd_ready_i,
    output logic [CntW-1:0]      count_o,
    output logic [CntW-1:0]      drop_o
);
    cfi_log_t [Depth-1:0] mem_q, mem_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d, free, push_cnt, drop_cnt;
    logic pop;
    assign rd_valid_o = count_q != '0;
    assign rd_data_o  = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign drop_o     = drop_cnt;
    always_comb begin
        free     = CntW'(Depth) - count_q;
        mem_d    = mem_q;
        push_cnt = '0;
        drop_cnt = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (wr_valid_i[i] && push_cnt < free) begin
                mem_d[wr_ptr_q + PtrW'(push_cnt)] = wr_data_i[i];
                push_cnt = push_cnt + CntW'(1);
            end else if (wr_valid_i[i]) begin
                drop_cnt = drop_cnt + CntW'(1);
            end
        end
        pop      = rd_valid_o && rd_ready_i;
        wr_ptr_d = wr_ptr_q + PtrW'(push_cnt);
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        count_d  = count_q + push_cnt - CntW'(pop);
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/cfi_log_buffer.sv
// cfi_log_buffer: filters committed control-flow instructions into a FIFO of CFI log records
module cfi_log_buffer
    import cfi_pkg::*;
#(
    parameter int unsigned NrCommitPorts = 2,
    parameter int unsigned Depth         = 8,
    parameter int unsigned CntWidth      = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NrCommitPorts-1:0]            commit_valid_i,
    input  cfi_flags_t [NrCommitPorts-1:0]      commit_flags_i,
    input  logic [NrCommitPorts-1:0][VLEN-1:0]  commit_pc_i,
    input  logic [NrCommitPorts-1:0][VLEN-1:0]  commit_npc_i,
    input  logic [NrCommitPorts-1:0][VLEN-1:0]  commit_target_i,
    output cfi_log_t                            log_o,
    output logic                                log_valid_o,
    input  logic                                log_ready_i,
    output logic                                commit_stall_o,
    output logic [CntWidth-1:0]                 dropped_o,
    output logic                                overflow_o
);
    localparam int unsigned CntW = $clog2(Depth) + 1;
    cfi_commit_t [NrCommitPorts-1:0] commit;
    cfi_log_t [NrCommitPorts-1:0] rec;
    logic [NrCommitPorts-1:0] cand;
    logic [CntW-1:0] count, drop;
    logic [CntWidth-1:0] dropped_q, dropped_d;
    logic [CntWidth:0] drop_sum;
    logic overflow_q, overflow_d;
    always_comb begin
        commit = '0;
        rec    = '0;
        cand   = '0;
        for (int i = 0; i < int'(NrCommitPorts); i++) begin
            commit[i] = '{valid: commit_valid_i[i], flags: commit_flags_i[i], pc: commit_pc_i[i],
                          npc: commit_npc_i[i], target: commit_target_i[i]};
            rec[i]    = '{flags: commit[i].flags, addr_pc: commit[i].pc,
                          addr_npc: commit[i].npc, addr_target: commit[i].target};
            cand[i]   = commit[i].valid && cfi_is_cf(commit[i].flags);
        end
    end
    cfi_multi_push_fifo #(.N(NrCommitPorts), .Depth(Depth)) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .wr_valid_i (cand),
        .wr_data_i  (rec),
        .rd_data_o  (log_o),
        .rd_valid_o (log_valid_o),
        .rd_ready_i (log_ready_i),
        .count_o    (count),
        .drop_o     (drop)
    );
    always_comb begin
        drop_sum   = {1'b0, dropped_q} + (CntWidth+1)'(drop);
        dropped_d  = drop_sum[CntWidth] ? '1 : drop_sum[CntWidth-1:0];
        overflow_d = overflow_q || (drop != '0);
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            dropped_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            dropped_q  <= dropped_d;
            overflow_q <= overflow_d;
        end
    end
    assign commit_stall_o = (CntW'(Depth) - count) < CntW'(NrCommitPorts);
    assign dropped_o      = dropped_q;
    assign overflow_o     = overflow_q;
endmodule

// File: tb/tb_cfi_log_buffer.sv
// tb_cfi_log_buffer: directed and random checks of cfi_log_buffer against a queue model
module tb_cfi_log_buffer;
    import cfi_pkg::*;
    localparam int NP = 2;
    localparam int DEPTH = 8;
    localparam int CW = 8;
    localparam cfi_flags_t F_NONE = 4'b0000;
    localparam cfi_flags_t F_RET  = 4'b0001;
    localparam cfi_flags_t F_CALL = 4'b0010;

    logic clk = 1'b0;
    logic rst_n;
    logic [NP-1:0] commit_valid;
    cfi_flags_t [NP-1:0] commit_flags;
    logic [NP-1:0][VLEN-1:0] pc, npc, tgt;
    cfi_log_t log_rec;
    logic log_valid, log_ready, stall, ovf;
    logic [CW-1:0] dropped;

    cfi_log_t mq[$];
    int unsigned m_drop;
    bit m_ovf;
    int checks = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    cfi_log_buffer #(.NrCommitPorts(NP), .Depth(DEPTH), .CntWidth(CW)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .commit_valid_i  (commit_valid),
        .commit_flags_i  (commit_flags),
        .commit_pc_i     (pc),
        .commit_npc_i    (npc),
        .commit_target_i (tgt),
        .log_o           (log_rec),
        .log_valid_o     (log_valid),
        .log_ready_i     (log_ready),
        .commit_stall_o  (stall),
        .dropped_o       (dropped),
        .overflow_o      (ovf)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        if (!rst_n) begin
            mq.delete();
            m_drop = 0;
            m_ovf = 1'b0;
        end else begin
            automatic int free = DEPTH - mq.size();
            automatic bit pop = (mq.size() != 0) && log_ready;
            automatic cfi_log_t add[$];
            for (int i = 0; i < NP; i++)
                if (commit_valid[i] && commit_flags[i] != F_NONE)
                    add.push_back('{commit_flags[i], pc[i], npc[i], tgt[i]});
            if (pop) void'(mq.pop_front());
            for (int i = 0; i < add.size(); i++) begin
                if (i < free) mq.push_back(add[i]);
                else begin
                    m_drop = (m_drop == 255) ? 255 : m_drop + 1;
                    m_ovf = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        if (cmp_en) begin
            chk("log_valid", log_valid, mq.size() != 0);
            if (mq.size() != 0) chk("log_o", log_rec, mq[0]);
            chk("commit_stall", stall, (DEPTH - mq.size()) < NP);
            chk("dropped", dropped, m_drop);
            chk("overflow", ovf, m_ovf);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    task automatic idle(input bit rdy);
        commit_valid = '0;
        commit_flags = '0;
        pc = '0;
        npc = '0;
        tgt = '0;
        log_ready = rdy;
    endtask

    task automatic put(input int i, input cfi_flags_t f, input logic [VLEN-1:0] p);
        commit_valid[i] = 1'b1;
        commit_flags[i] = f;
        pc[i] = p;
        npc[i] = p + 4;
        tgt[i] = p + 'h100;
    endtask

    initial begin
        rst_n = 1'b0;
        idle(1'b0);
        cmp_en = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_valid", log_valid, 0);
        chk("rst_log", log_rec, 0);
        chk("rst_stall", stall, 0);
        chk("rst_dropped", dropped, 0);
        chk("rst_overflow", ovf, 0);

        idle(1'b1);
        put(0, F_CALL, 'h1000);
        tgt[0] = 'h2000;
        tick();
        idle(1'b1);
        chk("single_valid", log_valid, 1);
        chk("single_flags", log_rec.flags, F_CALL);
        chk("single_pc", log_rec.addr_pc, 'h1000);
        chk("single_npc", log_rec.addr_npc, 'h1004);
        chk("single_target", log_rec.addr_target, 'h2000);
        tick();
        chk("single_gone", log_valid, 0);

        idle(1'b0);
        put(0, F_NONE, 'h2222);
        put(1, F_RET, 'h3000);
        tick();
        idle(1'b1);
        chk("filter_pc", log_rec.addr_pc, 'h3000);
        tick();
        chk("filter_one", log_valid, 0);
        put(0, F_CALL, 'h10);
        put(1, F_CALL, 'h14);
        tick();
        idle(1'b1);
        chk("order_first", log_rec.addr_pc, 'h10);
        tick();
        chk("order_second", log_rec.addr_pc, 'h14);
        tick();
        chk("order_empty", log_valid, 0);

        for (int b = 0; b < 3; b++) begin
            idle(1'b0);
            put(0, F_CALL, 'h100 + 8 * b);
            put(1, F_RET, 'h104 + 8 * b);
            tick();
        end
        idle(1'b0);
        chk("fill6_stall", stall, 0);
        put(0, F_CALL, 'h200);
        put(1, F_CALL, 'h204);
        tick();
        idle(1'b0);
        chk("fill8_stall", stall, 1);
        chk("fill8_dropped", dropped, 0);
        chk("fill8_overflow", ovf, 0);
        idle(1'b1);
        tick();
        idle(1'b0);
        chk("count7_stall", stall, 1);
        put(0, F_CALL, 'h300);
        put(1, F_CALL, 'h304);
        tick();
        idle(1'b0);
        chk("ovf_dropped", dropped, 1);
        chk("ovf_set", ovf, 1);
        idle(1'b1);
        put(0, F_CALL, 'h400);
        put(1, F_CALL, 'h404);
        tick();
        idle(1'b1);
        chk("fullpop_dropped", dropped, 3);
        chk("fullpop_valid", log_valid, 1);
        repeat (8) tick();
        chk("drain_empty", log_valid, 0);
        chk("drain_ovf_sticky", ovf, 1);
        chk("drain_stall", stall, 0);

        idle(1'b0);
        put(0, F_CALL, 'h500);
        put(1, F_CALL, 'h504);
        tick();
        put(0, F_CALL, 'h508);
        put(1, F_CALL, 'h50c);
        tick();
        idle(1'b0);
        put(0, F_CALL, 'h510);
        tick();
        idle(1'b0);
        rst_n = 1'b0;
        put(0, F_CALL, 'h999);
        tick();
        rst_n = 1'b1;
        idle(1'b0);
        chk("mrst_valid", log_valid, 0);
        chk("mrst_dropped", dropped, 0);
        chk("mrst_overflow", ovf, 0);
        chk("mrst_stall", stall, 0);
        tick();
        chk("mrst_no_push", log_valid, 0);

        for (int b = 0; b < 150; b++) begin
            idle(1'b0);
            put(0, cfi_flags_t'($urandom_range(1, 15)), VLEN'({$urandom(), $urandom()}));
            put(1, cfi_flags_t'($urandom_range(1, 15)), VLEN'({$urandom(), $urandom()}));
            tick();
        end
        idle(1'b0);
        chk("sat_dropped", dropped, 255);
        chk("sat_overflow", ovf, 1);

        for (int c = 0; c < 3000; c++) begin
            idle($urandom_range(0, 3) != 0);
            for (int i = 0; i < NP; i++) begin
                commit_valid[i] = $urandom_range(0, 1);
                commit_flags[i] = $urandom_range(0, 1) ? F_NONE : cfi_flags_t'($urandom_range(1, 15));
                pc[i] = VLEN'({$urandom(), $urandom()});
                npc[i] = VLEN'({$urandom(), $urandom()});
                tgt[i] = VLEN'({$urandom(), $urandom()});
            end
            rst_n = $urandom_range(0, 299) != 0;
            tick();
        end
        rst_n = 1'b1;
        idle(1'b1);
        tick();
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
